// File: rtl/controle_jogo_if.sv
// rtl/controle_jogo_if.sv - board-side signal bundle for the naval-battle game controller
//
// Purpose: groups the player buttons, map ROM handshake and display-facing
//          outputs of controle_jogo into one bundle.
// Ports (signals):
//   botao_liga_n, botao_confirma_n, botao_coluna_n, botao_linha_n : raw active-low buttons
//   navio          : map ROM data for endereco_mapa (1 = ship)
//   endereco_mapa  : {mapa, coordLinha, coordColuna}
//   ATAQUE, PREPARACAO, DESLIGADO : mode flags
//   coordColuna, coordLinha, mapa, vida, acertos : game registers
//   led_acerto, led_erro, vitoria, derrota : shot / result indicators
// Modports:
//   master : the game controller (drives game state, reads buttons and ROM)
//   slave  : the board side (buttons, ROM, display)

interface controle_jogo_if;
    logic       botao_liga_n;
    logic       botao_confirma_n;
    logic       botao_coluna_n;
    logic       botao_linha_n;
    logic       navio;
    logic [8:0] endereco_mapa;
    logic       ATAQUE;
    logic       PREPARACAO;
    logic       DESLIGADO;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic [2:0] mapa;
    logic [2:0] vida;
    logic [2:0] acertos;
    logic       led_acerto;
    logic       led_erro;
    logic       vitoria;
    logic       derrota;

    modport master (
        input  botao_liga_n, botao_confirma_n, botao_coluna_n, botao_linha_n, navio,
        output endereco_mapa, ATAQUE, PREPARACAO, DESLIGADO,
               coordColuna, coordLinha, mapa, vida, acertos,
               led_acerto, led_erro, vitoria, derrota
    );

    modport slave (
        output botao_liga_n, botao_confirma_n, botao_coluna_n, botao_linha_n, navio,
        input  endereco_mapa, ATAQUE, PREPARACAO, DESLIGADO,
               coordColuna, coordLinha, mapa, vida, acertos,
               led_acerto, led_erro, vitoria, derrota
    );
endinterface

// File: rtl/controle_jogo.sv
// rtl/controle_jogo.sv - naval-battle game controller FSM with button debouncers
//
// Purpose: debounces the four player buttons and sequences
//          DESL -> PREP -> ATQ -> FIM, owning cursor, map, lives, hits and
//          the 8x8 already-shot bitmap.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : controle_jogo_if.master (buttons, ROM handshake, display outputs)

module controle_jogo #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int VIDA_INICIAL    = 7,
    parameter int NUM_MAPAS       = 4,
    parameter int TOTAL_ALVOS     = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    controle_jogo_if.master  bus
);

    typedef enum logic [1:0] {
        DESL = 2'b00,
        PREP = 2'b01,
        ATQ  = 2'b10,
        FIM  = 2'b11
    } estado_t;

    localparam int            CW        = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [2:0]    VIDA_INI  = 3'(VIDA_INICIAL);
    localparam logic [2:0]    MAPA_MAX  = 3'(NUM_MAPAS - 1);
    localparam logic [2:0]    ALVOS     = 3'(TOTAL_ALVOS);

    // Button index: 0 liga, 1 confirma, 2 coluna, 3 linha
    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_estavel;
    logic [3:0]    r_pulso;
    logic [CW-1:0] r_cnt [4];

    assign w_raw = {bus.botao_linha_n, bus.botao_coluna_n,
                    bus.botao_confirma_n, bus.botao_liga_n};

    // The counter runs while the synced level differs from the accepted one;
    // any agreeing sample restarts it, so short glitches never get accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_estavel <= 4'hF;
            r_pulso   <= 4'h0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_pulso <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_estavel[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_estavel[i] <= r_sync2[i];
                    r_cnt[i]     <= '0;
                    r_pulso[i]   <= ~r_sync2[i];   // only the press edge pulses
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic w_liga, w_confirma, w_coluna, w_linha;
    assign w_liga     = r_pulso[0];
    assign w_confirma = r_pulso[1];
    assign w_coluna   = r_pulso[2];
    assign w_linha    = r_pulso[3];

    estado_t     r_estado;
    logic        r_ataque, r_prep, r_desl;
    logic [2:0]  r_col, r_lin, r_mapa, r_vida, r_acertos;
    logic [63:0] r_tiros;
    logic        r_led_acerto, r_led_erro, r_vitoria, r_derrota;

    logic [5:0]  w_idx;
    logic [2:0]  w_acertos_prox;
    logic [2:0]  w_vida_prox;

    assign w_idx          = {r_lin, r_col};
    assign w_acertos_prox = r_acertos + 3'd1;
    assign w_vida_prox    = r_vida - 3'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado     <= DESL;
            r_desl       <= 1'b1;
            r_prep       <= 1'b0;
            r_ataque     <= 1'b0;
            r_col        <= 3'd0;
            r_lin        <= 3'd0;
            r_mapa       <= 3'd0;
            r_vida       <= VIDA_INI;
            r_acertos    <= 3'd0;
            r_tiros      <= 64'd0;
            r_led_acerto <= 1'b0;
            r_led_erro   <= 1'b0;
            r_vitoria    <= 1'b0;
            r_derrota    <= 1'b0;
        end else if (w_liga) begin
            if (r_estado == DESL) begin
                r_estado <= PREP;
                r_desl   <= 1'b0;
                r_prep   <= 1'b1;
            end else begin
                // Power-off from any active state restores the reset image
                r_estado     <= DESL;
                r_desl       <= 1'b1;
                r_prep       <= 1'b0;
                r_ataque     <= 1'b0;
                r_col        <= 3'd0;
                r_lin        <= 3'd0;
                r_mapa       <= 3'd0;
                r_vida       <= VIDA_INI;
                r_acertos    <= 3'd0;
                r_tiros      <= 64'd0;
                r_led_acerto <= 1'b0;
                r_led_erro   <= 1'b0;
                r_vitoria    <= 1'b0;
                r_derrota    <= 1'b0;
            end
        end else begin
            case (r_estado)
                PREP: begin
                    if (w_confirma) begin
                        r_estado     <= ATQ;
                        r_prep       <= 1'b0;
                        r_ataque     <= 1'b1;
                        r_col        <= 3'd0;
                        r_lin        <= 3'd0;
                        r_vida       <= VIDA_INI;
                        r_acertos    <= 3'd0;
                        r_tiros      <= 64'd0;
                        r_led_acerto <= 1'b0;
                        r_led_erro   <= 1'b0;
                    end else if (w_coluna) begin
                        r_mapa <= (r_mapa == MAPA_MAX) ? 3'd0 : r_mapa + 3'd1;
                    end
                end
                ATQ: begin
                    if (w_confirma) begin
                        // Cursor moves arriving with a shot are dropped
                        if (!r_tiros[w_idx]) begin
                            r_tiros[w_idx] <= 1'b1;
                            if (bus.navio) begin
                                r_acertos    <= w_acertos_prox;
                                r_led_acerto <= 1'b1;
                                r_led_erro   <= 1'b0;
                                if (w_acertos_prox == ALVOS) begin
                                    r_estado  <= FIM;
                                    r_vitoria <= 1'b1;
                                end
                            end else if (r_vida != 3'd0) begin
                                r_vida       <= w_vida_prox;
                                r_led_erro   <= 1'b1;
                                r_led_acerto <= 1'b0;
                                if (w_vida_prox == 3'd0) begin
                                    r_estado  <= FIM;
                                    r_derrota <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        if (w_coluna) r_col <= r_col + 3'd1;
                        if (w_linha)  r_lin <= r_lin + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.endereco_mapa = {r_mapa, r_lin, r_col};
    assign bus.ATAQUE        = r_ataque;
    assign bus.PREPARACAO    = r_prep;
    assign bus.DESLIGADO     = r_desl;
    assign bus.coordColuna   = r_col;
    assign bus.coordLinha    = r_lin;
    assign bus.mapa          = r_mapa;
    assign bus.vida          = r_vida;
    assign bus.acertos       = r_acertos;
    assign bus.led_acerto    = r_led_acerto;
    assign bus.led_erro      = r_led_erro;
    assign bus.vitoria       = r_vitoria;
    assign bus.derrota       = r_derrota;

endmodule

// File: tb/tb_controle_jogo.sv
// tb/tb_controle_jogo.sv - directed self-checking bench for controle_jogo

module tb_controle_jogo;

    logic       clock;
    logic       reset_n;
    logic [3:0] r_bot;
    logic       r_navio;
    int         n_testes;
    int         n_falhas;

    controle_jogo_if u_if ();

    assign u_if.botao_liga_n     = r_bot[0];
    assign u_if.botao_confirma_n = r_bot[1];
    assign u_if.botao_coluna_n   = r_bot[2];
    assign u_if.botao_linha_n    = r_bot[3];
    assign u_if.navio            = r_navio;

    controle_jogo #(
        .DEBOUNCE_CICLOS (4),
        .VIDA_INICIAL    (7),
        .NUM_MAPAS       (4),
        .TOTAL_ALVOS     (5)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checa(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic espera(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    // Hold a button low long enough to be accepted, then release it
    task automatic aperta(input int b);
        r_bot[b] = 1'b0;
        espera(12);
        r_bot[b] = 1'b1;
        espera(12);
    endtask

    initial begin
        n_testes = 0;
        n_falhas = 0;
        r_bot    = 4'hF;
        r_navio  = 1'b0;
        reset_n  = 1'b0;
        espera(3);
        reset_n = 1'b1;
        espera(3);

        // Reset image
        checa("rst_desligado", 16'(u_if.DESLIGADO), 16'd1);
        checa("rst_ataque",    16'(u_if.ATAQUE),    16'd0);
        checa("rst_vida",      16'(u_if.vida),      16'd7);
        checa("rst_mapa",      16'(u_if.mapa),      16'd0);
        checa("rst_coords",    16'({u_if.coordLinha, u_if.coordColuna}), 16'd0);

        // Power on, cycle map selection 0,1,2,3,0,1
        aperta(0);
        checa("prep_flag", 16'(u_if.PREPARACAO), 16'd1);
        checa("prep_desl", 16'(u_if.DESLIGADO),  16'd0);
        for (int i = 0; i < 5; i++) aperta(2);
        checa("prep_mapa", 16'(u_if.mapa), 16'd1);
        aperta(3);
        checa("prep_linha_ign", 16'(u_if.coordLinha), 16'd0);

        // Start attack, move cursor
        aperta(1);
        checa("atq_flag", 16'(u_if.ATAQUE), 16'd1);
        checa("atq_prep", 16'(u_if.PREPARACAO), 16'd0);
        for (int i = 0; i < 9; i++) aperta(2);
        for (int i = 0; i < 3; i++) aperta(3);
        checa("atq_col",  16'(u_if.coordColuna), 16'd1);
        checa("atq_lin",  16'(u_if.coordLinha),  16'd3);
        checa("atq_addr", 16'(u_if.endereco_mapa), 16'h059);   // {1,3,1}

        // Miss twice on the same cell
        r_navio = 1'b0;
        aperta(1);
        checa("miss1_vida", 16'(u_if.vida), 16'd6);
        aperta(1);
        checa("miss2_vida", 16'(u_if.vida), 16'd6);
        checa("miss_led_erro",   16'(u_if.led_erro),   16'd1);
        checa("miss_led_acerto", 16'(u_if.led_acerto), 16'd0);

        // Five hits on columns 2..6 of row 3
        r_navio = 1'b1;
        for (int i = 0; i < 5; i++) begin
            aperta(2);
            aperta(1);
            if (i == 3) begin
                checa("hit4_acertos", 16'(u_if.acertos), 16'd4);
                checa("hit4_vitoria", 16'(u_if.vitoria), 16'd0);
            end
        end
        checa("win_acertos", 16'(u_if.acertos),    16'd5);
        checa("win_vitoria", 16'(u_if.vitoria),    16'd1);
        checa("win_derrota", 16'(u_if.derrota),    16'd0);
        checa("win_ataque",  16'(u_if.ATAQUE),     16'd1);
        checa("win_leds",    16'({u_if.led_acerto, u_if.led_erro}), 16'b10);
        aperta(2);
        checa("fim_col_frozen", 16'(u_if.coordColuna), 16'd6);

        // Power off from FIM
        aperta(0);
        checa("off_desl",    16'(u_if.DESLIGADO), 16'd1);
        checa("off_vida",    16'(u_if.vida),      16'd7);
        checa("off_acertos", 16'(u_if.acertos),   16'd0);
        checa("off_vitoria", 16'(u_if.vitoria),   16'd0);

        // Second game: 3-cycle glitch on confirma must not fire
        aperta(0);
        aperta(1);
        r_navio = 1'b0;
        r_bot[1] = 1'b0;
        espera(3);
        r_bot[1] = 1'b1;
        espera(12);
        checa("glitch_vida", 16'(u_if.vida),     16'd7);
        checa("glitch_led",  16'(u_if.led_erro), 16'd0);
        for (int i = 0; i < 3; i++) begin
            aperta(2);
            aperta(1);
        end
        checa("g2_vida", 16'(u_if.vida), 16'd4);

        // Asynchronous reset between clock edges
        reset_n = 1'b0;
        #1;
        checa("arst_desl",   16'(u_if.DESLIGADO), 16'd1);
        checa("arst_ataque", 16'(u_if.ATAQUE),    16'd0);
        checa("arst_vida",   16'(u_if.vida),      16'd7);
        espera(2);
        reset_n = 1'b1;
        espera(2);

        // Third game: seven misses lose
        aperta(0);
        aperta(1);
        r_navio = 1'b0;
        for (int i = 0; i < 7; i++) begin
            aperta(3);
            aperta(1);
            if (i == 5) checa("lose6_derrota", 16'(u_if.derrota), 16'd0);
        end
        checa("lose_vida",    16'(u_if.vida),    16'd0);
        checa("lose_derrota", 16'(u_if.derrota), 16'd1);
        checa("lose_vitoria", 16'(u_if.vitoria), 16'd0);
        aperta(1);
        checa("lose_vida_hold", 16'(u_if.vida), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
